// File: rtl/shift_iter_if.sv
// Request/result bus of the iterative shifter: operand handshake in, result handshake out.
interface shift_iter_if #(
    parameter int XLEN = 32
);
    localparam int SHW = $clog2(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [SHW-1:0]  shamt;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res;
    logic            busy;

    modport master (
        output in_valid, op, a, shamt, res_ready,
        input  in_ready, res_valid, res, busy
    );

    modport slave (
        input  in_valid, op, a, shamt, res_ready,
        output in_ready, res_valid, res, busy
    );
endinterface

// File: rtl/shift_iter.sv
// Low-area shifter: one bit position per clock for SLL/SRL/SRA, result held until taken.
// Define SHIFT_ITER_ROR_EN to enable op=11 rotate-right; otherwise op=11 returns a unchanged.
module shift_iter #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    shift_iter_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;

    logic [XLEN-1:0] step_left;
    logic [XLEN-1:0] step_right;
    logic [XLEN-1:0] step;
    logic            fill_msb;
    logic            op_supported;

    // Single-bit neighbour wiring for the left and right step paths.
    generate
        for (genvar gi = 0; gi < XLEN - 1; gi++) begin : g_step
            assign step_left[gi+1] = acc_q[gi];
            assign step_right[gi]  = acc_q[gi+1];
        end
    endgenerate

    assign step_left[0]        = 1'b0;
    assign step_right[XLEN-1]  = fill_msb;

    always_comb begin
        fill_msb = 1'b0;
        case (op_q)
            OP_SRA: fill_msb = acc_q[XLEN-1];
`ifdef SHIFT_ITER_ROR_EN
            OP_ROR: fill_msb = acc_q[0];
`endif
            default: fill_msb = 1'b0;
        endcase
    end

    assign step = (op_q == OP_SLL) ? step_left : step_right;

`ifdef SHIFT_ITER_ROR_EN
    assign op_supported = 1'b1;
`else
    assign op_supported = (bus.op != OP_ROR);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    acc_d = bus.a;
                    cnt_d = bus.shamt;
                    op_d  = bus.op;
                    // Zero shifts and unsupported ops skip straight to the result.
                    if ((bus.shamt == '0) || !op_supported) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Result is gated so partial accumulator values never leak out.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res       = (state_q == S_DONE) ? acc_q : '0;
    assign bus.busy      = (state_q == S_SHIFT) || (state_q == S_DONE);

endmodule

// File: tb/tb_shift_iter.sv
// Scoreboard bench for shift_iter: expected result/latency queued at accept, checked on res_valid.
module tb_shift_iter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_iter_if #(.XLEN(32)) bus ();

    shift_iter #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            2'b00:   r = a << sh;
            2'b01:   r = a >> sh;
            2'b10:   r = 32'($signed(a) >>> sh);
`ifdef SHIFT_ITER_ROR_EN
            default: r = (sh == 5'd0) ? a : ((a >> sh) | (a << (6'd32 - {1'b0, sh})));
`else
            default: r = a;
`endif
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [4:0] sh);
`ifdef SHIFT_ITER_ROR_EN
        return int'(sh) + 1;
`else
        return (op == 2'b11) ? 1 : int'(sh) + 1;
`endif
    endfunction

    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                           input int hold, input bit poke);
        int          lat;
        int          waitc;
        exp_t        e;
        logic [31:0] got;
        @(negedge clk);
        bus.op        = op;
        bus.a         = a;
        bus.shamt     = sh;
        bus.in_valid  = 1'b1;
        bus.res_ready = 1'b0;
        waitc = 0;
        while (!bus.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        e.res = model_res(op, a, sh);
        e.lat = model_lat(op, sh);
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs: the unit must have sampled them once at accept.
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.shamt    = 5'($urandom);
        bus.op       = 2'($urandom);
        lat = 1;
        while (!bus.res_valid && lat < 100) begin
            check("shift_res_gated", bus.res, 32'd0);
            check("shift_busy", 32'(bus.busy), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        got = bus.res;
        check("res", got, e.res);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.a        = $urandom;
                bus.shamt    = 5'($urandom);
            end
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_res", bus.res, e.res);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("release_valid", 32'(bus.res_valid), 32'd0);
        check("release_res", bus.res, 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        $display("txn op=%0d a=%h sh=%0d res=%h exp=%h lat=%0d hold=%0d",
                 op, a, sh, got, e.res, lat, hold);
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = 32'd0;
        bus.shamt     = 5'd0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_res", bus.res, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_req(2'b10, 32'h8000_0000, 5'd31, 0, 1'b0);
        run_req(2'b01, 32'h8000_0000, 5'd31, 0, 1'b0);
        run_req(2'b00, 32'h0000_00FF, 5'd0, 0, 1'b0);
        run_req(2'b00, 32'h0000_00FF, 5'd4, 0, 1'b0);
        run_req(2'b00, 32'h1234_5678, 5'd7, 10, 1'b1);
        run_req(2'b01, 32'hCAFE_F00D, 5'd3, 0, 1'b0);
        run_req(2'b11, 32'h0000_0001, 5'd1, 0, 1'b0);
        run_req(2'b11, 32'hA5A5_0003, 5'd9, 1, 1'b0);

        // Reset in the middle of a shift: the request must vanish.
        @(negedge clk);
        check("pre_rst_ready", 32'(bus.in_ready), 32'd1);
        bus.op       = 2'b00;
        bus.a        = 32'h8000_0001;
        bus.shamt    = 5'd20;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_shift_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.res_valid), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen++;
        end
        check("no_result_after_rst", 32'(seen), 32'd0);
        $display("txn reset mid-shift a=80000001 sh=20 results_seen=%0d", seen);

        for (int n = 0; n < 1500; n++) begin
            run_req(2'($urandom), $urandom, 5'($urandom), int'($urandom_range(0, 2)),
                    1'($urandom));
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
